// File: rtl/carbonz380_simctl_if.sv
// CarbonZ380 simctl I/O bus: one request channel (valid/ready) and one
// single-cycle read response channel.
interface carbonz380_simctl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata
  );
endinterface

// File: rtl/carbonz380_simctl.sv
// CarbonZ380 simulation-control device: signature assembly, console FIFO
// and a poweroff sequencer that drains the console before reporting off.
module carbonz380_simctl #(
  parameter logic [7:0] IO_BASE   = 8'h80,
  parameter int         CON_DEPTH = 4,
  parameter logic [7:0] OFF_MAGIC = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  carbonz380_simctl_if.slave bus,
  output logic               con_valid,
  output logic [7:0]         con_data,
  input  logic               con_ready,
  output logic [31:0]        signature,
  output logic               poweroff
);

  localparam int PW = $clog2(CON_DEPTH);
  localparam logic [PW:0] ONE_PTR = {{PW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OFF   = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] sig_r;
  logic [2:0]  sig_cnt_r;
  logic        bad_magic_r;
  logic [PW:0] wr_ptr_r;
  logic [PW:0] rd_ptr_r;
  logic [7:0]  fifo_mem_r [CON_DEPTH];
  logic        rsp_valid_r;
  logic [7:0]  rsp_rdata_r;

  logic        hit_s;
  logic [2:0]  off_s;
  logic        empty_s;
  logic        full_s;
  logic [PW:0] count_s;
  logic        con_wr_s;
  logic        ready_s;
  logic        accept_s;
  logic        wr_acc_s;
  logic        rd_acc_s;
  logic        push_s;
  logic        pop_s;
  logic        drain_done_s;
  logic [7:0]  rd_data_s;

  assign hit_s   = (bus.req_addr[7:3] == IO_BASE[7:3]);
  assign off_s   = bus.req_addr[2:0];
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  // Pointers carry one extra bit so full and empty differ only in the MSB.
  assign full_s  = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                   (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign count_s = wr_ptr_r - rd_ptr_r;

  // Only a console write into a full FIFO stalls; once off, console
  // writes are swallowed so they must never block the bus.
  assign con_wr_s = bus.req_valid && bus.req_we && hit_s && (off_s == 3'd2);
  assign ready_s  = !(con_wr_s && full_s && (state_r != ST_OFF));
  assign accept_s = bus.req_valid && ready_s;
  assign wr_acc_s = accept_s && bus.req_we && hit_s;
  assign rd_acc_s = accept_s && !bus.req_we;
  assign push_s   = wr_acc_s && (off_s == 3'd2) && (state_r != ST_OFF);
  assign pop_s    = !empty_s && con_ready;

  // Drain finishes when nothing is left after this cycle's pop and no new
  // byte is entering on the same edge.
  assign drain_done_s = !push_s && (empty_s || ((count_s == ONE_PTR) && pop_s));

  // Read data mux from current (pre-edge) register state.
  always_comb begin
    rd_data_s = 8'hFF;
    if (hit_s) begin
      case (off_s)
        3'd0:    rd_data_s = {5'b0_0000, sig_cnt_r};
        3'd1:    rd_data_s = 8'h00;
        3'd2:    rd_data_s = 8'h00;
        3'd3:    rd_data_s = {4'b0000, bad_magic_r, full_s, empty_s, (state_r == ST_OFF)};
        3'd4:    rd_data_s = {6'b00_0000, state_r};
        default: rd_data_s = 8'hFF;
      endcase
    end else begin
      rd_data_s = 8'hFF;
    end
  end

  // Poweroff sequencer next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (wr_acc_s && (off_s == 3'd4) && (bus.req_wdata == OFF_MAGIC)) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_done_s) begin
          state_next_s = ST_OFF;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_OFF:  state_next_s = ST_OFF;
      default: state_next_s = ST_RUN;
    endcase
  end

  // Poweroff sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Signature shift register and saturating write counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_r     <= 32'h0000_0000;
      sig_cnt_r <= 3'd0;
    end else if (wr_acc_s && (off_s == 3'd0)) begin
      sig_r <= {bus.req_wdata, sig_r[31:8]};
      if (sig_cnt_r != 3'd7) begin
        sig_cnt_r <= sig_cnt_r + 3'd1;
      end
    end else if (wr_acc_s && (off_s == 3'd1)) begin
      sig_r     <= 32'h0000_0000;
      sig_cnt_r <= 3'd0;
    end
  end

  // Sticky flag for a wrong poweroff value written while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_magic_r <= 1'b0;
    end else if (wr_acc_s && (off_s == 3'd4) && (state_r == ST_RUN) &&
                 (bus.req_wdata != OFF_MAGIC)) begin
      bad_magic_r <= 1'b1;
    end
  end

  // Console FIFO pointers; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
    end
  end

  // Console FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[PW-1:0]] <= bus.req_wdata;
    end
  end

  // One-cycle read response; data holds until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 8'h00;
    end else begin
      rsp_valid_r <= rd_acc_s;
      if (rd_acc_s) begin
        rsp_rdata_r <= rd_data_s;
      end
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign con_valid     = !empty_s;
  assign con_data      = fifo_mem_r[rd_ptr_r[PW-1:0]];
  assign signature     = sig_r;
  assign poweroff      = (state_r == ST_OFF);

endmodule

// File: tb/tb_carbonz380_simctl.sv
// Bench for carbonz380_simctl: a transaction-level model (queue FIFO,
// mode number, shift-in signature) checked every cycle, plus literal pins.
module tb_carbonz380_simctl;

  localparam logic [7:0] BASE  = 8'h80;
  localparam int         DEPTH = 4;
  localparam logic [7:0] MAGIC = 8'hA5;

  logic        clk;
  logic        rst;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic [31:0] signature;
  logic        poweroff;

  carbonz380_simctl_if bus();

  carbonz380_simctl #(
    .IO_BASE  (BASE),
    .CON_DEPTH(DEPTH),
    .OFF_MAGIC(MAGIC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .con_valid(con_valid),
    .con_data (con_data),
    .con_ready(con_ready),
    .signature(signature),
    .poweroff (poweroff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [31:0] m_sig;
  int          m_cnt;
  bit          m_bad;
  int          m_mode;   // 0 run, 1 drain, 2 off
  logic [7:0]  m_q[$];
  bit          m_rsp_v;
  logic [7:0]  m_rsp_d;
  bit          last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit();
    return bus.req_addr[7:3] == BASE[7:3];
  endfunction

  function automatic bit m_ready();
    return !(bus.req_valid && bus.req_we && m_hit() && bus.req_addr[2:0] == 3'd2 &&
             m_q.size() == DEPTH && m_mode != 2);
  endfunction

  function automatic logic [7:0] m_read();
    if (!m_hit()) return 8'hFF;
    case (bus.req_addr[2:0])
      3'd0: return 8'(m_cnt);
      3'd1: return 8'h00;
      3'd2: return 8'h00;
      3'd3: return {4'b0000, m_bad, m_q.size() == DEPTH, m_q.size() == 0, m_mode == 2};
      3'd4: return 8'(m_mode);
      default: return 8'hFF;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs present at it.
  task automatic model_edge();
    logic [7:0] rv;
    bit acc;
    bit pop;
    bit push;
    int old_mode;
    if (rst) begin
      m_sig = 32'h0; m_cnt = 0; m_bad = 1'b0; m_mode = 0;
      m_q.delete(); m_rsp_v = 1'b0; m_rsp_d = 8'h00; last_acc = 1'b0;
      return;
    end
    acc = bus.req_valid && m_ready();
    last_acc = acc;
    rv = m_read();
    m_rsp_v = acc && !bus.req_we;
    if (m_rsp_v) m_rsp_d = rv;
    pop = (m_q.size() != 0) && con_ready;
    push = 1'b0;
    old_mode = m_mode;
    if (acc && bus.req_we && m_hit()) begin
      case (bus.req_addr[2:0])
        3'd0: begin
          m_sig = {bus.req_wdata, m_sig[31:8]};
          if (m_cnt < 7) m_cnt++;
        end
        3'd1: begin m_sig = 32'h0; m_cnt = 0; end
        3'd2: push = (m_mode != 2);
        3'd4: if (m_mode == 0) begin
          if (bus.req_wdata == MAGIC) m_mode = 1;
          else m_bad = 1'b1;
        end
        default: ;
      endcase
    end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(bus.req_wdata);
    if (old_mode == 1 && m_q.size() == 0) m_mode = 2;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", {31'b0, bus.req_ready}, {31'b0, m_ready()});
      chk("con_valid", {31'b0, con_valid}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) chk("con_data", {24'b0, con_data}, {24'b0, m_q[0]});
      chk("signature", signature, m_sig);
      chk("poweroff", {31'b0, poweroff}, {31'b0, m_mode == 2});
      chk("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, m_rsp_v});
      chk("rsp_rdata", {24'b0, bus.rsp_rdata}, {24'b0, m_rsp_d});
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input bit we, input logic [7:0] a, input logic [7:0] d);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  task automatic wait_acc();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 50);
    chk("accept_timeout", {31'b0, last_acc}, 32'd1);
  endtask

  task automatic io(input bit we, input logic [7:0] a, input logic [7:0] d);
    drive(1'b1, we, a, d);
    wait_acc();
  endtask

  task automatic rd_lit(input string name, input logic [7:0] a, input logic [7:0] exp);
    io(1'b0, a, 8'h00);
    chk({name, "_v"}, {31'b0, bus.rsp_valid}, 32'd1);
    chk(name, {24'b0, bus.rsp_rdata}, {24'b0, exp});
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1;
    con_ready = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_signature", signature, 32'h0);
    chk("rst_con_valid", {31'b0, con_valid}, 32'd0);
    chk("rst_poweroff", {31'b0, poweroff}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {24'b0, bus.rsp_rdata}, 32'd0);
    rst = 1'b0;

    // Signature assembly, back to back
    io(1'b1, BASE, 8'h5A);
    io(1'b1, BASE, 8'h33);
    io(1'b1, BASE, 8'h38);
    io(1'b1, BASE, 8'h30);
    rd_lit("sig_cnt4", BASE, 8'h04);
    chk("sig_value", signature, 32'h3038_335A);
    idle(1);

    // FIFO fill, stall, release
    con_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) io(1'b1, BASE + 8'd2, 8'hC0 + 8'(i));
    rd_lit("status_full", BASE + 8'd3, 8'h04);
    drive(1'b1, 1'b1, BASE + 8'd2, 8'hCF);
    tick();
    tick();
    chk("stall_ready", {31'b0, bus.req_ready}, 32'd0);
    con_ready = 1'b1;
    wait_acc();
    idle(6);
    chk("fifo_drained", {31'b0, con_valid}, 32'd0);

    // Decode edges, saturation, clear
    rd_lit("rsvd6", BASE + 8'd6, 8'hFF);
    rd_lit("nodecode", BASE ^ 8'h08, 8'hFF);
    for (int i = 0; i < 4; i++) io(1'b1, BASE, 8'h11 + 8'(i));
    rd_lit("sig_cnt_sat", BASE, 8'h07);
    io(1'b1, BASE + 8'd1, 8'h00);
    idle(1);
    chk("sigclr", signature, 32'h0);
    rd_lit("sig_cnt_clr", BASE, 8'h00);

    // Bad magic, then good magic with empty FIFO
    io(1'b1, BASE + 8'd4, 8'h5A);
    rd_lit("status_bad", BASE + 8'd3, 8'h0A);
    rd_lit("fsm_run", BASE + 8'd4, 8'h00);
    chk("bad_no_off", {31'b0, poweroff}, 32'd0);
    io(1'b1, BASE + 8'd4, MAGIC);
    rd_lit("fsm_drain_empty", BASE + 8'd4, 8'h01);
    chk("off_2cyc", {31'b0, poweroff}, 32'd1);
    io(1'b1, BASE + 8'd2, 8'h77);
    io(1'b1, BASE, 8'h99);
    idle(2);
    chk("off_drop_con", {31'b0, con_valid}, 32'd0);
    chk("off_sig", signature, 32'h9900_0000);

    // Drain with three queued bytes
    rst = 1'b1;
    tick();
    rst = 1'b0;
    con_ready = 1'b0;
    io(1'b1, BASE + 8'd2, 8'hA1);
    io(1'b1, BASE + 8'd2, 8'hA2);
    io(1'b1, BASE + 8'd2, 8'hA3);
    io(1'b1, BASE + 8'd4, MAGIC);
    rd_lit("fsm_drain", BASE + 8'd4, 8'h01);
    chk("drain_not_off", {31'b0, poweroff}, 32'd0);
    idle(0);
    con_ready = 1'b1;
    tick();
    tick();
    chk("drain_mid_off", {31'b0, poweroff}, 32'd0);
    chk("drain_mid_cv", {31'b0, con_valid}, 32'd1);
    tick();
    chk("drain_off", {31'b0, poweroff}, 32'd1);
    chk("drain_empty", {31'b0, con_valid}, 32'd0);
    idle(3);
    chk("off_sticky", {31'b0, poweroff}, 32'd1);

    // Reset in the middle of a drain, with a write in flight
    rst = 1'b1;
    tick();
    rst = 1'b0;
    con_ready = 1'b0;
    io(1'b1, BASE, 8'h42);
    io(1'b1, BASE + 8'd2, 8'hB1);
    io(1'b1, BASE + 8'd2, 8'hB2);
    io(1'b1, BASE + 8'd4, MAGIC);
    drive(1'b1, 1'b1, BASE, 8'hEE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstd_con_valid", {31'b0, con_valid}, 32'd0);
    chk("rstd_poweroff", {31'b0, poweroff}, 32'd0);
    chk("rstd_signature", signature, 32'h0);
    rd_lit("rstd_fsm", BASE + 8'd4, 8'h00);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
